stim_controller: RTL
====================

// Module: stim_controller
// PURPOSE
//  Closed-loop stimulation controller directly downstream of datapath. Consumes the per-sample
//  seizure flag (datapath.stimulation) qualified by the sample strobe (en). After CONFIRM_COUNT
//  consecutive positive samples, emits a fixed train of stimulation pulses, then enforces a
//  refractory period before re-arming. Drives the stimulator front end and an event counter.
// PARAMETERS
//  CONFIRM_COUNT  4    consecutive qualified detects needed to fire (>=1)
//  PULSE_WIDTH    3    clk cycles per pulse phase (>=1)
//  PULSE_PERIOD   10   clk cycles, pulse start to next pulse start (>PULSE_WIDTH; >2*PULSE_WIDTH if biphasic)
//  NUM_PULSES     5    pulses per train (>=1)
//  REFRACTORY     50   clk cycles of lockout after the last pulse phase (>=1)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-low reset (0 = reset)
//  en           in   1   sample-valid strobe; detect is sampled only when en=1
//  detect       in   1   seizure flag from datapath.stimulation
//  abort        in   1   synchronous; kills the train/confirm and returns to IDLE
//  stim_out     out  1   positive (cathodic) pulse phase, registered
//  stim_neg     out  1   negative phase (STIM_BIPHASIC_EN only; else constant 0)
//  busy         out  1   1 in PULSE_HI/PULSE_NEG/PULSE_LO/REFRACT
//  pulse_idx    out  8   index of current pulse in train, 0..NUM_PULSES-1; 0 when not busy
//  train_count  out  16  completed trains since reset; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs, confirm counter and timers = 0.
//  States: IDLE, CONFIRM, PULSE_HI, PULSE_NEG, PULSE_LO, REFRACT. All outputs are registered.
//  IDLE: en&detect -> conf=1; if CONFIRM_COUNT==1 go PULSE_HI, else go CONFIRM.
//  CONFIRM: en&detect -> conf+1; conf reaching CONFIRM_COUNT -> PULSE_HI. en&!detect -> conf=0, IDLE.
//   en=0 cycles hold conf (gaps between samples do not break the run).
//  Latency: stim_out=1 in the cycle after the edge that registers the qualifying detect.
//  PULSE_HI: PULSE_WIDTH cycles of stim_out=1 -> PULSE_NEG (biphasic) or next step.
//  PULSE_NEG: PULSE_WIDTH cycles of stim_neg=1; stim_out=0.
//  After the active phase(s): if pulse_idx<NUM_PULSES-1 -> PULSE_LO for the rest of PULSE_PERIOD,
//   then pulse_idx+1, PULSE_HI. Last pulse -> REFRACT directly (no trailing LO).
//  REFRACT: REFRACTORY cycles, detect ignored, conf held 0; on exit train_count+1, pulse_idx=0, IDLE.
//  abort=1 in any state: next edge -> IDLE, stim_out=stim_neg=0, conf=0, train_count unchanged.
//   abort has priority over detect in the same cycle.
//  stim_out and stim_neg are never 1 in the same cycle.
//  Timers: down-counters of width $clog2(max(PULSE_PERIOD,REFRACTORY)+1); no wrap inside a state.
//  Train length (monophasic) = (NUM_PULSES-1)*PULSE_PERIOD + PULSE_WIDTH cycles.
// CONFIGURATION
//  `STIM_BIPHASIC_EN defined: PULSE_NEG is entered after each PULSE_HI (charge-balanced pulse);
//   PULSE_LO lasts PULSE_PERIOD-2*PULSE_WIDTH.
//  Not defined: PULSE_NEG is unreachable, stim_neg tied 0, PULSE_LO lasts PULSE_PERIOD-PULSE_WIDTH.
// STRUCTURE
//  stim_pkg: state encoding localparams (3-bit), default timing constants, output width constants;
//   shared with datapath top and the testbench.
//  Sub-module: stim_timer (loadable down-counter with done flag), one instance for all phases.
// TESTING (defaults, monophasic unless noted)
//  1. en=detect=1 for 4 consecutive samples -> stim_out high 3 cycles, 5 pulses at period 10,
//     busy falls 93 cycles after the first stim_out=1 (43 train + 50 refract), train_count=1.
//  2. 3 detects, then en=1/detect=0, then 4 detects -> no pulse after first run; one train after
//     the 4th of the second run.
//  3. detect held 1 throughout -> train, REFRACT ignores detect; next train starts only after
//     4 new samples post-REFRACT.
//  4. detect=1 with en=0 for 20 cycles -> no state change; detects interleaved with en=0 gaps
//     still fire after the 4th qualifying sample.
//  5. abort=1 during 2nd pulse high -> stim_out=0 next cycle, busy=0, pulse_idx=0, train_count
//     unchanged; rst=0 mid-pulse -> all outputs 0 immediately without a clock edge.
//  6. STIM_BIPHASIC_EN: each pulse = 3 cycles stim_out then 3 cycles stim_neg, 4 low, period 10;
//     never both high.

Source files
------------

// File: rtl/stim_pkg.sv
// Shared state encoding, default timing and output widths for the stimulation controller.
// Also imported by the datapath top and the testbench.
package stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CONFIRM   = 3'd1,
    ST_PULSE_HI  = 3'd2,
    ST_PULSE_NEG = 3'd3,
    ST_PULSE_LO  = 3'd4,
    ST_REFRACT   = 3'd5
  } stim_state_e;

  localparam int STIM_CONFIRM_COUNT = 4;
  localparam int STIM_PULSE_WIDTH   = 3;
  localparam int STIM_PULSE_PERIOD  = 10;
  localparam int STIM_NUM_PULSES    = 5;
  localparam int STIM_REFRACTORY    = 50;

  localparam int STIM_IDX_W       = 8;
  localparam int STIM_TRAIN_CNT_W = 16;

  function automatic int stim_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stim_timer.sv
// Loadable down-counter shared by every timed phase; done is high while the count is zero.
// A load takes effect on the next edge and overrides the decrement.
module stim_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/stim_controller.sv
// Closed-loop stimulation controller: confirms N consecutive detects, fires a pulse train, then locks out.
// Define STIM_BIPHASIC_EN to add a charge-balancing negative phase after every positive phase.
module stim_controller
  import stim_pkg::*;
#(
  parameter int CONFIRM_COUNT = STIM_CONFIRM_COUNT,
  parameter int PULSE_WIDTH   = STIM_PULSE_WIDTH,
  parameter int PULSE_PERIOD  = STIM_PULSE_PERIOD,
  parameter int NUM_PULSES    = STIM_NUM_PULSES,
  parameter int REFRACTORY    = STIM_REFRACTORY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        detect,
  input  logic                        abort,
  output logic                        stim_out,
  output logic                        stim_neg,
  output logic                        busy,
  output logic [STIM_IDX_W-1:0]       pulse_idx,
  output logic [STIM_TRAIN_CNT_W-1:0] train_count
);

  localparam int TW = $clog2(stim_max(PULSE_PERIOD, REFRACTORY) + 1);
  localparam int CW = $clog2(CONFIRM_COUNT + 1);
`ifdef STIM_BIPHASIC_EN
  localparam int ACTIVE = 2 * PULSE_WIDTH;
`else
  localparam int ACTIVE = PULSE_WIDTH;
`endif
  // Timer loads are duration-1 because a phase exits in the cycle its count reads zero.
  localparam logic [TW-1:0] PW_LD = TW'(PULSE_WIDTH - 1);
  localparam logic [TW-1:0] LO_LD = TW'(PULSE_PERIOD - ACTIVE - 1);
  localparam logic [TW-1:0] RF_LD = TW'(REFRACTORY - 1);

  stim_state_e                 state_q, state_d;
  logic [CW-1:0]               conf_q, conf_d;
  logic [STIM_IDX_W-1:0]       idx_q, idx_d;
  logic [STIM_TRAIN_CNT_W-1:0] cnt_q, cnt_d;
  logic                        stim_out_q, busy_q;
  logic                        tmr_load, tmr_done, end_active;
  logic [TW-1:0]               tmr_val;

  stim_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d    = state_q;
    conf_d     = conf_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    end_active = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      conf_d  = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (en && detect) begin
          if (CONFIRM_COUNT == 1) begin
            state_d  = ST_PULSE_HI;
            tmr_load = 1'b1;
            tmr_val  = PW_LD;
          end else begin
            state_d = ST_CONFIRM;
            conf_d  = CW'(1);
          end
        end
        ST_CONFIRM: if (en) begin
          if (!detect) begin
            state_d = ST_IDLE;
            conf_d  = '0;
          end else if (conf_q == CW'(CONFIRM_COUNT - 1)) begin
            state_d  = ST_PULSE_HI;
            conf_d   = '0;
            tmr_load = 1'b1;
            tmr_val  = PW_LD;
          end else begin
            conf_d = conf_q + CW'(1);
          end
        end
        ST_PULSE_HI: if (tmr_done) begin
`ifdef STIM_BIPHASIC_EN
          state_d  = ST_PULSE_NEG;
          tmr_load = 1'b1;
          tmr_val  = PW_LD;
`else
          end_active = 1'b1;
`endif
        end
`ifdef STIM_BIPHASIC_EN
        ST_PULSE_NEG: if (tmr_done) end_active = 1'b1;
`endif
        ST_PULSE_LO: if (tmr_done) begin
          state_d  = ST_PULSE_HI;
          idx_d    = idx_q + STIM_IDX_W'(1);
          tmr_load = 1'b1;
          tmr_val  = PW_LD;
        end
        ST_REFRACT: if (tmr_done) begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = cnt_q + STIM_TRAIN_CNT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
      // The last pulse goes straight into lockout with no trailing low gap.
      if (end_active) begin
        tmr_load = 1'b1;
        if (idx_q == STIM_IDX_W'(NUM_PULSES - 1)) begin
          state_d = ST_REFRACT;
          tmr_val = RF_LD;
        end else begin
          state_d = ST_PULSE_LO;
          tmr_val = LO_LD;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      conf_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      stim_out_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      conf_q     <= conf_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      stim_out_q <= (state_d == ST_PULSE_HI);
      busy_q     <= (state_d == ST_PULSE_HI) || (state_d == ST_PULSE_NEG) ||
                    (state_d == ST_PULSE_LO) || (state_d == ST_REFRACT);
    end
  end

`ifdef STIM_BIPHASIC_EN
  logic stim_neg_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stim_neg_q <= 1'b0;
    else      stim_neg_q <= (state_d == ST_PULSE_NEG);
  end
  assign stim_neg = stim_neg_q;
`else
  assign stim_neg = 1'b0;
`endif

  assign stim_out    = stim_out_q;
  assign busy        = busy_q;
  assign pulse_idx   = idx_q;
  assign train_count = cnt_q;

endmodule
